// File: rtl/fetch_queue.sv
// Multi-wide circular instruction queue between fetch and decode with mispredict flush.
// Latency: enqueued entries are presented one cycle later; presentation reads are combinational.
// Backpressure: in_ready drops when fewer than FETCH_W entries are free; decode takes all valid slots or none.
module fetch_queue #(
  parameter int DEPTH    = 8,
  parameter int FETCH_W  = 2,
  parameter int DECODE_W = 2,
  parameter int XLEN     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mispredict,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]  in_count,
  input  logic [FETCH_W*XLEN-1:0]       in_instr,
  input  logic [XLEN-1:0]               in_pc,
  output logic [DECODE_W-1:0]           out_valid,
  input  logic                          out_ready,
  output logic [DECODE_W*XLEN-1:0]      out_instr,
  output logic [DECODE_W*XLEN-1:0]      out_pc,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [31:0]                   stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FETCH_W+1);

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [31:0]     stall_q, stall_d;
  logic [OW-1:0]   free_cnt;
  logic [OW-1:0]   deq_n;
  logic            enq;
  logic            deq;

  // Entry storage is deliberately left unreset; only pointers/occupancy qualify it.
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pc_mem_d    [DEPTH];

  // Credit check uses registered occupancy only; a same-cycle dequeue is not counted as free space.
  always_comb begin
    free_cnt = OW'(DEPTH) - occ_q;
    in_ready = (free_cnt >= OW'(FETCH_W));
    deq_n    = (occ_q < OW'(DECODE_W)) ? occ_q : OW'(DECODE_W);
  end

  // Present the oldest min(occupancy, DECODE_W) entries; a mispredict hides them this cycle.
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int i = 0; i < DECODE_W; i++) begin
      out_valid[i]              = (OW'(i) < deq_n) && !mispredict;
      out_instr[i*XLEN +: XLEN] = instr_mem_q[head_q + PW'(i)];
      out_pc[i*XLEN +: XLEN]    = pc_mem_q[head_q + PW'(i)];
    end
  end

  assign enq = in_valid && in_ready && !mispredict;
  assign deq = out_ready && (|out_valid);

  // Write the used slots of an accepted group at tail onward, deriving each slot's PC from in_pc.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (enq) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (CW'(i) < in_count) begin
          instr_mem_d[tail_q + PW'(i)] = in_instr[i*XLEN +: XLEN];
          pc_mem_d[tail_q + PW'(i)]    = in_pc + XLEN'(4*i);
        end
      end
    end
  end

  // Pointer, occupancy and stall-counter next state; mispredict empties the queue outright.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (mispredict) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PW'(in_count);
      end
      if (deq) begin
        head_d = head_q + PW'(deq_n);
      end
      occ_d = occ_q + (enq ? OW'(in_count) : '0) - (deq ? deq_n : '0);
    end
  end

  // Control state with synchronous reset, which also outranks mispredict.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

  // Storage update without reset.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

  // A valid fetch group must carry between 1 and FETCH_W instructions.
  a_in_count_legal: assert property (@(posedge clk) disable iff (reset)
    in_valid |-> ((in_count != '0) && (in_count <= CW'(FETCH_W))));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
// Latency: model follows the DUT one registered cycle at a time.
// Backpressure: model derives readiness and dequeue size from its own entry count.
module tb_fetch_queue;

  localparam int DEPTH    = 8;
  localparam int FETCH_W  = 2;
  localparam int DECODE_W = 2;
  localparam int XLEN     = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mispredict;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_count;
  logic [2*XLEN-1:0]     in_instr;
  logic [XLEN-1:0]       in_pc;
  logic [1:0]            out_valid;
  logic                  out_ready;
  logic [2*XLEN-1:0]     out_instr;
  logic [2*XLEN-1:0]     out_pc;
  logic [3:0]            occupancy;
  logic [31:0]           stall_cycles;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DECODE_W(DECODE_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of {pc, instr} entries plus stall counter.
  logic [63:0] mq[$];
  logic [31:0] m_stall = 0;
  bit          seen_reset = 0;

  always @(posedge clk) begin
    int sz;
    int n;
    bit rdy;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      m_stall = 0;
      seen_reset = 1;
    end else if (seen_reset) begin
      rdy = (DEPTH - sz) >= FETCH_W;
      n = (sz < DECODE_W) ? sz : DECODE_W;
      if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (mispredict) begin
        mq.delete();
      end else begin
        if (out_ready && n > 0) repeat (n) void'(mq.pop_front());
        if (in_valid && rdy)
          for (int i = 0; i < int'(in_count); i++)
            mq.push_back({in_pc + 32'(4*i), in_instr[i*XLEN +: XLEN]});
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    int sz;
    int n;
    logic [1:0] exp_v;
    if (seen_reset && !reset) begin
      sz = mq.size();
      n = (sz < DECODE_W) ? sz : DECODE_W;
      exp_v = '0;
      for (int i = 0; i < DECODE_W; i++) exp_v[i] = (i < n) && !mispredict;
      chk("cmp_in_ready", 64'(in_ready), 64'((DEPTH - sz) >= FETCH_W));
      chk("cmp_out_valid", 64'(out_valid), 64'(exp_v));
      chk("cmp_occupancy", 64'(occupancy), 64'(sz));
      chk("cmp_stall", 64'(stall_cycles), 64'(m_stall));
      if (!mispredict) begin
        for (int i = 0; i < n; i++) begin
          chk("cmp_instr", 64'(out_instr[i*XLEN +: XLEN]), 64'(mq[i][31:0]));
          chk("cmp_pc", 64'(out_pc[i*XLEN +: XLEN]), 64'(mq[i][63:32]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] cnt, input logic [31:0] pc);
    in_valid = v;
    in_count = cnt;
    in_pc    = pc;
    in_instr = {pc ^ 32'hA5A5_0004, pc ^ 32'hA5A5_0000};
  endtask

  logic [31:0] exp_cons;

  task automatic wrap_take();
    if (out_valid[0]) begin
      chk("wrap_order", 64'(out_pc[31:0]), 64'(exp_cons));
      exp_cons = exp_cons + (out_valid[1] ? 32'd8 : 32'd4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; mispredict = 0; out_ready = 0;
    drive(0, 2'd0, 32'h0);
    cyc(); cyc();
    reset = 0;
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_stall", 64'(stall_cycles), 64'd0);

    // Basic flow
    in_valid = 1; in_count = 2; in_pc = 32'h1000; in_instr = {32'h0010_0093, 32'h0000_0013};
    cyc();
    in_valid = 0; out_ready = 1;
    #1;
    chk("basic_valid", 64'(out_valid), 64'h3);
    chk("basic_pc", 64'(out_pc), {32'h1004, 32'h1000});
    chk("basic_instr", 64'(out_instr), {32'h0010_0093, 32'h0000_0013});
    chk("basic_occ", 64'(occupancy), 64'd2);
    cyc();
    chk("basic_drained", 64'(occupancy), 64'd0);
    out_ready = 0;

    // Fill and stall
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'd2, 32'h3000 + 32'(8*k));
      cyc();
    end
    drive(1, 2'd2, 32'h3100);
    repeat (3) cyc();
    in_valid = 0;
    chk("fill_occ", 64'(occupancy), 64'd8);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_stall", 64'(stall_cycles), 64'd3);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_keep_pc", 64'(out_pc), {32'h3004 + 32'(8*k), 32'h3000 + 32'(8*k)});
      cyc();
    end
    chk("fill_empty", 64'(occupancy), 64'd0);

    // Partial groups with pointer wrap, dequeuing every cycle
    exp_cons = 32'h7000;
    begin
      logic [31:0] pc;
      pc = 32'h7000;
      for (int k = 0; k < 20; k++) begin
        drive(1, (k % 2 == 0) ? 2'd1 : 2'd2, pc);
        pc = pc + ((k % 2 == 0) ? 32'd4 : 32'd8);
        #1;
        wrap_take();
        cyc();
      end
    end
    in_valid = 0;
    repeat (3) begin
      #1;
      wrap_take();
      cyc();
    end
    chk("wrap_total", 64'(exp_cons), 64'(32'h7000 + 32'd120));
    out_ready = 0;

    // Odd occupancy
    drive(1, 2'd1, 32'h4000);
    cyc();
    in_valid = 0;
    chk("odd_valid", 64'(out_valid), 64'h1);
    chk("odd_occ", 64'(occupancy), 64'd1);
    out_ready = 1;
    cyc();
    chk("odd_drained", 64'(occupancy), 64'd0);
    chk("odd_no_valid", 64'(out_valid), 64'd0);
    out_ready = 0;

    // Simultaneous enqueue and dequeue
    drive(1, 2'd2, 32'h5000); cyc();
    drive(1, 2'd2, 32'h5008); cyc();
    drive(1, 2'd2, 32'h5010); out_ready = 1;
    cyc();
    in_valid = 0; out_ready = 0;
    chk("simul_occ", 64'(occupancy), 64'd4);
    chk("simul_head", 64'(out_pc), {32'h500C, 32'h5008});
    out_ready = 1;
    cyc();
    chk("simul_new", 64'(out_pc), {32'h5014, 32'h5010});
    cyc();
    chk("simul_empty", 64'(occupancy), 64'd0);
    out_ready = 0;

    // Flush
    drive(1, 2'd2, 32'h6000); cyc();
    drive(1, 2'd2, 32'h6008); cyc();
    drive(1, 2'd2, 32'h6010); cyc();
    chk("flush_pre_occ", 64'(occupancy), 64'd6);
    drive(1, 2'd2, 32'h6018); out_ready = 1; mispredict = 1;
    #1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc();
    mispredict = 0; in_valid = 0; out_ready = 0;
    chk("flush_occ", 64'(occupancy), 64'd0);
    drive(1, 2'd2, 32'h2000);
    cyc();
    in_valid = 0;
    chk("flush_refill_pc", 64'(out_pc[31:0]), 64'h2000);
    chk("flush_refill_occ", 64'(occupancy), 64'd2);
    chk("flush_keeps_stall", 64'(stall_cycles), 64'd3);

    // Reset during mispredict
    mispredict = 1; reset = 1;
    cyc();
    mispredict = 0; reset = 0;
    chk("rst_mp_stall", 64'(stall_cycles), 64'd0);
    chk("rst_mp_occ", 64'(occupancy), 64'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
